// File: rtl/lsu_ram_master_if.sv
// Request, response and RAM-side signal bundle for lsu_ram_master.
// The master modport is the LSU's view; slave is the requester/RAM side.
interface lsu_ram_master_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic [WIDTH-1:0] ram_wr_data;
  logic [WIDTH-1:0] ram_rd_data;
  logic             ram_rdEn;
  logic             ram_wrEn;
  logic [WIDTH-1:0] ram_addr;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, ram_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_wr_data, ram_rdEn, ram_wrEn, ram_addr
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, ram_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_wr_data, ram_rdEn, ram_wrEn, ram_addr
  );
endinterface

// File: rtl/lsu_ram_master.sv
// Load/store unit front end for a single-port synchronous word RAM, with byte/half
// read-modify-write. Define MISALIGN_TRAP_EN to turn misaligned half/word accesses into errors.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are both high;
// req_ready is high only in IDLE, and rsp_valid/rsp_rdata/rsp_err hold until rsp_ready.
module lsu_ram_master #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_ram_master_if.master  bus,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_WAIT  = 3'd2,
    RMW_RD   = 3'd3,
    RMW_WAIT = 3'd4,
    WR       = 3'd5,
    RESP     = 3'd6
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        signed_q;
  logic [15:0] wdata_q;
  logic        acc_err;

  assign dbg_state = state;

  always_comb begin
    acc_err = (bus.req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if (bus.req_size == 2'b01 && bus.req_addr[0])
      acc_err = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
      acc_err = 1'b1;
`endif
  end

  function automatic logic [WIDTH-1:0] load_ext(input logic [WIDTH-1:0] w,
                                                input logic [1:0] size,
                                                input logic [1:0] lane,
                                                input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_ext = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   load_ext = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Only byte and half stores reach the merge; word stores bypass the read.
  function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] w,
                                                   input logic [1:0] size,
                                                   input logic [1:0] lane,
                                                   input logic [15:0] d);
    logic [WIDTH-1:0] m;
    m = w;
    if (size == 2'b00)
      m[{lane, 3'b000} +: 8] = d[7:0];
    else if (lane[1])
      m[31:16] = d;
    else
      m[15:0] = d;
    store_merge = m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      size_q          <= 2'b00;
      lane_q          <= 2'b00;
      signed_q        <= 1'b0;
      wdata_q         <= '0;
      bus.req_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.ram_wr_data <= '0;
      bus.ram_rdEn    <= 1'b0;
      bus.ram_wrEn    <= 1'b0;
      bus.ram_addr    <= '0;
    end else begin
      bus.ram_rdEn <= 1'b0;
      bus.ram_wrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            size_q        <= bus.req_size;
            lane_q        <= bus.req_addr[1:0];
            signed_q      <= bus.req_signed;
            wdata_q       <= bus.req_wdata[15:0];
            if (acc_err) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              state         <= RESP;
            end else begin
              bus.ram_addr <= {bus.req_addr[WIDTH-1:2], 2'b00};
              if (!bus.req_we) begin
                bus.ram_rdEn <= 1'b1;
                state        <= RD;
              end else if (bus.req_size == 2'b10) begin
                bus.ram_wr_data <= bus.req_wdata;
                bus.ram_wrEn    <= 1'b1;
                state           <= WR;
              end else begin
                bus.ram_rdEn <= 1'b1;
                state        <= RMW_RD;
              end
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          bus.rsp_rdata <= load_ext(bus.ram_rd_data, size_q, lane_q, signed_q);
          bus.rsp_err   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RMW_RD: state <= RMW_WAIT;
        RMW_WAIT: begin
          bus.ram_wr_data <= store_merge(bus.ram_rd_data, size_q, lane_q, wdata_q);
          bus.ram_wrEn    <= 1'b1;
          state           <= WR;
        end
        WR: begin
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_ram_master.md
LSU_RAM_MASTER -- requirements
Module: lsu_ram_master

Interface
REQ-001 Parameter: WIDTH, 32, data and address width; only 32 is supported.
REQ-002 Ports are listed as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response held until taken.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected, no RAM access made.
- ram_wr_data  out  32  RAM write data.
- ram_rd_data  in  32  RAM read data, valid the cycle after ram_rdEn.
- ram_rdEn  out  1  RAM read enable.
- ram_wrEn  out  1  RAM write enable; the write commits at the rising edge.
- ram_addr  out  32  word address, bits [1:0] always 00.
REQ-003 There is one clock (clk) and reset (rst_n) is asynchronous and active-low.

Function
REQ-004 The FSM shall use states IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR and RESP; every output shall be decoded from registers only, so no output depends combinationally on an input.
REQ-005 req_ready = 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-006 From IDLE, the next state on accept is:
- illegal size or misalignment error -> RESP
- load -> RD
- word store -> WR
- byte/half store -> RMW_RD
REQ-007 RD and RMW_RD shall assert ram_rdEn=1 with ram_addr={addr[31:2],2'b00}; the next state is RD_WAIT or RMW_WAIT respectively.
REQ-008 RD_WAIT shall capture ram_rd_data, extract the addressed lane, extend it, register it into rsp_rdata, and go to RESP.
REQ-009 RMW_WAIT shall merge the store bytes into the captured word, place the result on ram_wr_data, and go to WR.
REQ-010 WR shall assert ram_wrEn=1 for exactly one cycle and go to RESP.
REQ-011 RESP shall hold rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1, then go to IDLE; there is no back-to-back acceptance in RESP.
REQ-012 Latency, counted in edges from the accept edge to rsp_valid=1: load 3, word store 2, sub-word store 4, error 1.
REQ-013 Byte lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-014 ram_rdEn and ram_wrEn shall never be high in the same cycle; both are 0 outside RD/RMW_RD/WR.
REQ-015 Request fields shall be registered at accept; later input changes have no effect on the transaction in flight.

Reset
REQ-016 Asserting rst_n=0 shall immediately force IDLE and drive every output to 0, including req_ready=0.
REQ-017 After reset deassertion, req_ready=1 from the first cycle.
REQ-018 A reset taken mid-transaction shall abandon it: no RAM write commits and no response is produced.

Configuration
REQ-019 Macro MISALIGN_TRAP_EN.
- Defined: a half with addr[0]=1 or a word with addr[1:0]!=00 -> rsp_err=1, no RAM access.
- Undefined: the offending low address bits are ignored (half uses addr[1], word uses the aligned word), and no error is raised for alignment.
- Illegal size is an error in both builds.

Verification
REQ-020 Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, load latency 3.
REQ-021 With word 0x11223344 stored at 0x20, store byte 0xAA to addr 0x22, then word load from 0x20 -> 0x11AA3344.
REQ-022 With word 0x80FF7F01 at 0x30:
- signed byte load from 0x32 -> 0xFFFFFFFF
- unsigned byte load from 0x32 -> 0x000000FF
- signed half load from 0x30 -> 0x00007F01
REQ-023 Half load from 0x41:
- MISALIGN_TRAP_EN defined -> rsp_err=1, ram_rdEn never asserted.
- Undefined -> data from lane addr[1]=0, rsp_err=0.
REQ-024 Hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, outputs stable, req_ready=0 throughout.
REQ-025 Pull rst_n low during WR of a store to 0x50 -> the word at 0x50 is unchanged, rsp_valid=0, and the FSM is in IDLE after release.
